// File: rtl/audio_i2s_capture_if.sv
// Write side of the audio dual-clock FIFO: one-cycle write strobe,
// 32-bit stereo word, and the FIFO's full flag coming back.
interface audio_i2s_capture_if;
    logic        wrreq;
    logic [31:0] wrdata;
    logic        wrfull;

    modport master (output wrreq, output wrdata, input wrfull);
    modport slave  (input wrreq, input wrdata, output wrfull);
endinterface

// File: rtl/audio_i2s_capture.sv
// AICA serial audio capture: oversamples BCLK/LRCK/SDATA in the system
// clock domain, assembles one {left, right} word per LRCK period and
// pushes it into the audio FIFO write port.
module audio_i2s_capture #(
    parameter int BITS        = 16,
    parameter int DATA_DELAY  = 1,
    parameter int LEFT_LEVEL  = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       bclk,
    input  logic                       lrck,
    input  logic                       sdata,
    input  logic                       clear_overflow,
    audio_i2s_capture_if.master        fifo,
    output logic                       overflow,
    output logic                       frame_error,
    output logic [7:0]                 dropped
);

    localparam int   BCW      = $clog2(BITS + 1);
    localparam int   DCW      = (DATA_DELAY > 0) ? $clog2(DATA_DELAY + 1) : 1;
    localparam int   PAD      = 16 - BITS;
    localparam logic LEFT_LVL = 1'(LEFT_LEVEL);
    localparam logic [BCW-1:0] BITS_W  = BCW'(BITS);
    localparam logic [DCW-1:0] DD_INIT = DCW'((DATA_DELAY > 0) ? DATA_DELAY - 1 : 0);

    typedef enum logic [1:0] {HUNT, LEFT, RIGHT} state_t;

    // [stage][{bclk, lrck, sdata}]
    logic [SYNC_STAGES-1:0][2:0] sync_q;
    logic                        bclk_d;
    logic                        bclk_s, lrck_s, sdata_s;
    logic                        rise, start, new_left;
    logic                        prev_lrck;

    state_t          state, state_nx;
    logic [BITS-1:0] sreg, sreg_nx, left_reg;
    logic [BCW-1:0]  bcnt, bcnt_nx;
    logic [DCW-1:0]  dcnt;
    logic            cap, dly_tick, begin_ch, ld_left, emit, ferr;
    logic            emit_q, drop;
    logic [15:0]     l16, r16;

    assign {bclk_s, lrck_s, sdata_s} = sync_q[SYNC_STAGES-1];
    assign rise     = bclk_s & ~bclk_d;
    assign start    = rise & (lrck_s != prev_lrck);
    assign new_left = (lrck_s == LEFT_LVL);

    // Equal-depth synchronisers for all three serial inputs, plus BCLK edge history
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
            bclk_d <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], {bclk, lrck, sdata}};
            bclk_d <= bclk_s;
        end
    end

    // Frame state register
    always_ff @(posedge clock) begin
        if (reset) state <= HUNT;
        else       state <= state_nx;
    end

    // Next state and control. A bit landing on the same rise as a channel
    // start (I2S LSB) is folded in first, so the start sees the full count.
    always_comb begin
        state_nx = state;
        begin_ch = 1'b0;
        ld_left  = 1'b0;
        emit     = 1'b0;
        ferr     = 1'b0;
        cap      = rise && (state != HUNT) && (dcnt == '0) && (bcnt < BITS_W);
        dly_tick = rise && (state != HUNT) && (dcnt != '0);
        sreg_nx  = cap ? BITS'({sreg, sdata_s}) : sreg;
        bcnt_nx  = cap ? BCW'(bcnt + 1'b1) : bcnt;
        if (start) begin
            case (state)
                HUNT: begin
                    if (new_left) begin
                        state_nx = LEFT;
                        begin_ch = 1'b1;
                    end
                end
                LEFT: begin
                    if (bcnt_nx == BITS_W && !new_left) begin
                        state_nx = RIGHT;
                        begin_ch = 1'b1;
                        ld_left  = 1'b1;
                    end else begin
                        // short left channel: drop back and re-evaluate this rise as HUNT would
                        ferr = 1'b1;
                        if (new_left) begin
                            state_nx = LEFT;
                            begin_ch = 1'b1;
                        end else begin
                            state_nx = HUNT;
                        end
                    end
                end
                RIGHT: begin
                    if (new_left && bcnt_nx == BITS_W) emit = 1'b1;
                    else                               ferr = 1'b1;
                    if (new_left) begin
                        state_nx = LEFT;
                        begin_ch = 1'b1;
                    end else begin
                        state_nx = HUNT;
                    end
                end
                default: state_nx = HUNT;
            endcase
        end
        l16 = 16'(left_reg) << PAD;
        r16 = 16'(sreg_nx) << PAD;
    end

    // Shift register, bit/delay counters, left holding register and output word
    always_ff @(posedge clock) begin
        if (reset) begin
            sreg        <= '0;
            bcnt        <= '0;
            dcnt        <= '0;
            left_reg    <= '0;
            prev_lrck   <= 1'b0;
            emit_q      <= 1'b0;
            fifo.wrdata <= '0;
        end else begin
            if (rise) prev_lrck <= lrck_s;
            if (ld_left) left_reg <= sreg_nx;
            emit_q <= emit;
            if (emit) fifo.wrdata <= {l16, r16};
            if (begin_ch) begin
                if (DATA_DELAY == 0) begin
                    // MSB arrives on the start rise itself
                    sreg <= BITS'(sdata_s);
                    bcnt <= BCW'(1);
                end else begin
                    sreg <= '0;
                    bcnt <= '0;
                end
                dcnt <= DD_INIT;
            end else if (cap) begin
                sreg <= sreg_nx;
                bcnt <= bcnt_nx;
            end else if (dly_tick) begin
                dcnt <= dcnt - 1'b1;
            end
        end
    end

    // Write strobe in the cycle after the closing rise, suppressed when full
    assign fifo.wrreq = emit_q & ~fifo.wrfull & ~reset;
    assign drop       = emit_q & fifo.wrfull;

    // Sticky status; a new drop or frame error beats a coincident clear
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow    <= 1'b0;
            frame_error <= 1'b0;
            dropped     <= '0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
                if (clear_overflow)        dropped <= 8'd1;
                else if (dropped != 8'hFF) dropped <= dropped + 8'd1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
                dropped  <= '0;
            end
            if (ferr)                frame_error <= 1'b1;
            else if (clear_overflow) frame_error <= 1'b0;
        end
    end

endmodule

// File: tb/tb_audio_i2s_capture.sv
// Directed bench: an I2S capture (DATA_DELAY=1) and a left-justified capture
// (DATA_DELAY=0) share BCLK/LRCK, each with its own SDATA line and FIFO port.
`timescale 1ns/1ps
module tb_audio_i2s_capture;

    localparam int HALF = 10;  // system clocks per BCLK half period

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic bclk  = 1'b0;
    logic lrck  = 1'b1;
    logic sdata_i = 1'b0;
    logic sdata_l = 1'b0;
    logic clear_overflow = 1'b0;
    logic overflow_i, frame_error_i, overflow_l, frame_error_l;
    logic [7:0] dropped_i, dropped_l;

    audio_i2s_capture_if fi ();
    audio_i2s_capture_if fl ();

    audio_i2s_capture #(.BITS(16), .DATA_DELAY(1), .LEFT_LEVEL(0), .SYNC_STAGES(2)) dut_i2s (
        .clock(clock), .reset(reset), .bclk(bclk), .lrck(lrck), .sdata(sdata_i),
        .clear_overflow(clear_overflow), .fifo(fi),
        .overflow(overflow_i), .frame_error(frame_error_i), .dropped(dropped_i)
    );

    audio_i2s_capture #(.BITS(16), .DATA_DELAY(0), .LEFT_LEVEL(0), .SYNC_STAGES(2)) dut_lj (
        .clock(clock), .reset(reset), .bclk(bclk), .lrck(lrck), .sdata(sdata_l),
        .clear_overflow(clear_overflow), .fifo(fl),
        .overflow(overflow_l), .frame_error(frame_error_l), .dropped(dropped_l)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_pass = 0;
    int wr_i = 0, wr_l = 0, consec = 0;
    logic [31:0] last_i = '0, last_l = '0;
    logic prev_wi = 1'b0, prev_wl = 1'b0;
    logic pend_i = 1'b0;

    // Write monitor, sampled on the falling edge
    always @(negedge clock) begin
        if (fi.wrreq) begin wr_i++; last_i = fi.wrdata; end
        if (fl.wrreq) begin wr_l++; last_l = fl.wrdata; end
        if ((fi.wrreq && prev_wi) || (fl.wrreq && prev_wl)) consec++;
        prev_wi = fi.wrreq;
        prev_wl = fl.wrreq;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One BCLK period; the I2S line carries the left-justified bit one slot late.
    task automatic slot(input logic lr, input logic bi, input logic bl);
        @(negedge clock);
        lrck    = lr;
        sdata_i = pend_i;
        pend_i  = bi;
        sdata_l = bl;
        repeat (HALF) @(negedge clock);
        bclk = 1'b1;
        repeat (HALF) @(negedge clock);
        bclk = 1'b0;
    endtask

    task automatic chan(input logic lr, input logic [15:0] vi, input logic [15:0] vl, input int n);
        for (int j = 0; j < n; j++) slot(lr, vi[15-j], vl[15-j]);
    endtask

    task automatic frame(input logic [15:0] li, input logic [15:0] ri);
        chan(1'b0, li, 16'h8001, 16);
        chan(1'b1, ri, 16'h7FFE, 16);
    endtask

    initial begin
        fi.wrfull = 1'b0;
        fl.wrfull = 1'b0;
        repeat (4) @(negedge clock);
        check("rst_wrreq",    {31'd0, fi.wrreq},      32'd0);
        check("rst_wrdata",   fi.wrdata,              32'd0);
        check("rst_overflow", {31'd0, overflow_i},    32'd0);
        check("rst_ferr",     {31'd0, frame_error_i}, 32'd0);
        check("rst_dropped",  {24'd0, dropped_i},     32'd0);
        check("rst_lj_wrdata", fl.wrdata,             32'd0);
        reset = 1'b0;

        // stream joins mid right channel; that tail must be ignored
        chan(1'b1, 16'h5A5A, 16'hFFFF, 8);
        frame(16'h1234, 16'hABCD);
        check("no_partial_emit", wr_i, 0);
        frame(16'h1234, 16'hABCD);
        check("first_cnt",   wr_i,   1);
        check("first_word",  last_i, 32'h1234ABCD);
        check("lj_cnt",      wr_l,   1);
        check("lj_word",     last_l, 32'h80017FFE);
        check("aligned_no_ferr", {31'd0, frame_error_i}, 32'd0);
        frame(16'hA5C3, 16'h0F0F);
        check("second_cnt",  wr_i,   2);
        check("second_word", last_i, 32'h1234ABCD);

        // FIFO full across three emits
        fi.wrfull = 1'b1;
        frame(16'h1111, 16'h2222);
        frame(16'h3333, 16'h4444);
        frame(16'h5555, 16'h6666);
        check("full_cnt",      wr_i, 2);
        check("full_overflow", {31'd0, overflow_i}, 32'd1);
        check("full_dropped",  {24'd0, dropped_i},  32'd3);
        fi.wrfull = 1'b0;
        frame(16'h7777, 16'h8888);
        check("resume_cnt",  wr_i,   3);
        check("resume_word", last_i, 32'h55556666);
        @(negedge clock) clear_overflow = 1'b1;
        @(negedge clock) clear_overflow = 1'b0;
        check("clr_overflow", {31'd0, overflow_i}, 32'd0);
        check("clr_dropped",  {24'd0, dropped_i},  32'd0);

        // left channel cut short after 10 data bits
        chan(1'b0, 16'hFFFF, 16'h8001, 11);
        chan(1'b1, 16'h0000, 16'h7FFE, 16);
        frame(16'h1357, 16'h2468);
        check("short_ferr", {31'd0, frame_error_i}, 32'd1);
        check("short_cnt",  wr_i,   4);
        check("short_word", last_i, 32'h77778888);
        frame(16'h9999, 16'hAAAA);
        check("recover_cnt",  wr_i,   5);
        check("recover_word", last_i, 32'h13572468);

        // reset pulse in the middle of a right channel
        chan(1'b0, 16'hCAFE, 16'h8001, 16);
        chan(1'b1, 16'hBEEF, 16'h7FFE, 8);
        check("pre_rst_word", last_i, 32'h9999AAAA);
        @(negedge clock) reset = 1'b1;
        @(negedge clock) reset = 1'b0;
        check("mid_rst_wrreq",  {31'd0, fi.wrreq},      32'd0);
        check("mid_rst_wrdata", fi.wrdata,              32'd0);
        check("mid_rst_ferr",   {31'd0, frame_error_i}, 32'd0);
        check("mid_rst_ovf",    {31'd0, overflow_i},    32'd0);
        chan(1'b1, 16'hBEEF, 16'h7FFE, 8);
        frame(16'h0BAD, 16'hF00D);
        check("post_rst_none", wr_i, 6);
        frame(16'h1234, 16'hABCD);
        check("post_rst_cnt",  wr_i,   7);
        check("post_rst_word", last_i, 32'h0BADF00D);
        check("lj_total",      wr_l,   10);
        check("lj_last",       last_l, 32'h80017FFE);
        check("no_back_to_back", consec, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
